// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant states, CTI codes
// and the width helper for the optional stb timeout counter (WB_ARB_TIMEOUT_EN).
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    function automatic int unsigned tmo_width(input int unsigned timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_mux.sv
// Combinational grant-indexed mux: routes the granted master onto the slave bus and
// returns slave responses only to that master. kill squashes cyc/stb and forces err.
module wb_arb_mux
    import wb_arb_pkg::*;
#(
    parameter int ADDRESS = 25
) (
    input  state_t               gnt,
    input  logic                 kill,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [2:0]           m0_cti_i,
    input  logic [1:0]           m0_bte_i,
    input  logic [ADDRESS-1:0]   m0_adr_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [31:0]          m0_dat_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [2:0]           m1_cti_i,
    input  logic [1:0]           m1_bte_i,
    input  logic [ADDRESS-1:0]   m1_adr_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [31:0]          m1_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_rty_i,
    input  logic                 s_err_i,
    input  logic [31:0]          s_dat_i,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    output logic [ADDRESS-1:0]   s_adr_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_rty_o,
    output logic                 m0_err_o,
    output logic [31:0]          m0_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_rty_o,
    output logic                 m1_err_o,
    output logic [31:0]          m1_dat_o
);

    // Read data is broadcast; masters qualify it with their own ack.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_cti_o  = CTI_CLASSIC;
        s_bte_o  = 2'b00;
        s_adr_o  = '0;
        s_sel_o  = 4'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m0_rty_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_rty_o = 1'b0;
        m1_err_o = 1'b0;
        case (gnt)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i & ~kill;
                s_stb_o  = m0_stb_i & ~kill;
                s_we_o   = m0_we_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_cyc_i;
                m0_rty_o = s_rty_i & m0_cyc_i;
                m0_err_o = (s_err_i & m0_cyc_i) | kill;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i & ~kill;
                s_stb_o  = m1_stb_i & ~kill;
                s_we_o   = m1_we_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_cyc_i;
                m1_rty_o = s_rty_i & m1_cyc_i;
                m1_err_o = (s_err_i & m1_cyc_i) | kill;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter; a grant is held for a whole cyc.
// Define WB_ARB_TIMEOUT_EN to force an error on a slave that never answers stb.
//
// state   | meaning
// IDLE    | no grant, slave bus quiet, rearbitration point
// GNT0    | master 0 owns the slave until m0_cyc_i drops
// GNT1    | master 1 owns the slave until m1_cyc_i drops
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int ADDRESS = 25,
    parameter int TIMEOUT = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [2:0]           m0_cti_i,
    input  logic [1:0]           m0_bte_i,
    input  logic [ADDRESS-1:0]   m0_adr_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [31:0]          m0_dat_i,
    output logic                 m0_ack_o,
    output logic                 m0_rty_o,
    output logic                 m0_err_o,
    output logic [31:0]          m0_dat_o,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [2:0]           m1_cti_i,
    input  logic [1:0]           m1_bte_i,
    input  logic [ADDRESS-1:0]   m1_adr_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [31:0]          m1_dat_i,
    output logic                 m1_ack_o,
    output logic                 m1_rty_o,
    output logic                 m1_err_o,
    output logic [31:0]          m1_dat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    output logic [ADDRESS-1:0]   s_adr_o,
    output logic [3:0]           s_sel_o,
    output logic [31:0]          s_dat_o,
    input  logic                 s_ack_i,
    input  logic                 s_rty_i,
    input  logic                 s_err_i,
    input  logic [31:0]          s_dat_i
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_arb2: TIMEOUT must be at least 2");
    end

    state_t state;
    logic   last;
    logic   tmo_hit;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = tmo_width(TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt;
    logic             gnt_stb;
    logic             resp;

    assign gnt_stb = ((state == ST_GNT0) && m0_cyc_i && m0_stb_i) ||
                     ((state == ST_GNT1) && m1_cyc_i && m1_stb_i);
    assign resp    = s_ack_i | s_rty_i | s_err_i;
    // A response in the final cycle still wins over the forced error.
    assign tmo_hit = gnt_stb && !resp && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt <= '0;
        end else if (!gnt_stb || resp || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // last names the master served most recently; on contention the other one wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= ST_GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= ST_GNT1;
                        last  <= 1'b1;
                    end
                end
                ST_GNT0: if (!m0_cyc_i || tmo_hit) state <= ST_IDLE;
                ST_GNT1: if (!m1_cyc_i || tmo_hit) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    wb_arb_mux #(.ADDRESS(ADDRESS)) u_mux (
        .gnt      (state),
        .kill     (tmo_hit),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_cti_i (m0_cti_i),
        .m0_bte_i (m0_bte_i),
        .m0_adr_i (m0_adr_i),
        .m0_sel_i (m0_sel_i),
        .m0_dat_i (m0_dat_i),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_cti_i (m1_cti_i),
        .m1_bte_i (m1_bte_i),
        .m1_adr_i (m1_adr_i),
        .m1_sel_i (m1_sel_i),
        .m1_dat_i (m1_dat_i),
        .s_ack_i  (s_ack_i),
        .s_rty_i  (s_rty_i),
        .s_err_i  (s_err_i),
        .s_dat_i  (s_dat_i),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),
        .s_adr_o  (s_adr_o),
        .s_sel_o  (s_sel_o),
        .s_dat_o  (s_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_rty_o (m0_rty_o),
        .m0_err_o (m0_err_o),
        .m0_dat_o (m0_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_rty_o (m1_rty_o),
        .m1_err_o (m1_err_o),
        .m1_dat_o (m1_dat_o)
    );

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: arbitration table, hand-written corner sequences,
// and randomized two-master traffic against a transaction-level reference model.
module tb_wb_arb2;
    import wb_arb_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        rst_n    = 1'b0;
    logic        mcyc[2], mstb[2], mwe[2];
    logic [2:0]  mcti[2];
    logic [1:0]  mbte[2];
    logic [24:0] madr[2];
    logic [3:0]  msel[2];
    logic [31:0] mdat[2];
    logic        m0_ack, m0_rty, m0_err, m1_ack, m1_rty, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we, s_ack, s_rty, s_err;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [24:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_wdat, s_rdat;
    logic [31:0] bram[256];
    logic [31:0] ref_mem[256];
    int          slv_mode = 0;   // 0 ack, 1 retry, 2 error, 3 never answer
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct { bit r0; bit r1; int exp; } arb_vec_t;
    arb_vec_t tbl[9];

    always #5 wb_clk_i = ~wb_clk_i;

    wb_arb2 #(.ADDRESS(25), .TIMEOUT(8)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_ni (rst_n),
        .m0_cyc_i (mcyc[0]), .m0_stb_i (mstb[0]), .m0_we_i (mwe[0]), .m0_cti_i (mcti[0]),
        .m0_bte_i (mbte[0]), .m0_adr_i (madr[0]), .m0_sel_i (msel[0]), .m0_dat_i (mdat[0]),
        .m0_ack_o (m0_ack), .m0_rty_o (m0_rty), .m0_err_o (m0_err), .m0_dat_o (m0_rdat),
        .m1_cyc_i (mcyc[1]), .m1_stb_i (mstb[1]), .m1_we_i (mwe[1]), .m1_cti_i (mcti[1]),
        .m1_bte_i (mbte[1]), .m1_adr_i (madr[1]), .m1_sel_i (msel[1]), .m1_dat_i (mdat[1]),
        .m1_ack_o (m1_ack), .m1_rty_o (m1_rty), .m1_err_o (m1_err), .m1_dat_o (m1_rdat),
        .s_cyc_o (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we), .s_cti_o (s_cti),
        .s_bte_o (s_bte), .s_adr_o (s_adr), .s_sel_o (s_sel), .s_dat_o (s_wdat),
        .s_ack_i (s_ack), .s_rty_i (s_rty), .s_err_i (s_err), .s_dat_i (s_rdat)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 8) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(i));
    endfunction

    // Zero-wait-state slave answering in the same cycle as stb.
    always_comb begin
        s_ack = 1'b0;
        s_rty = 1'b0;
        s_err = 1'b0;
        if (s_cyc && s_stb) begin
            case (slv_mode)
                0: s_ack = 1'b1;
                1: s_rty = 1'b1;
                2: s_err = 1'b1;
                default: ;
            endcase
        end
    end
    assign s_rdat = bram[s_adr[9:2]];

    always @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
        end else if (s_ack && s_we) begin
            bram[s_adr[9:2]] <= s_wdat;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic req(input int n, input logic we, input logic [24:0] adr,
                       input logic [31:0] dat, input logic [2:0] cti);
        mcyc[n] = 1'b1; mstb[n] = 1'b1; mwe[n] = we; madr[n] = adr;
        mdat[n] = dat;  mcti[n] = cti;  msel[n] = 4'hF; mbte[n] = 2'b00;
    endtask

    task automatic drop(input int n);
        mcyc[n] = 1'b0; mstb[n] = 1'b0;
    endtask

    function automatic logic ack_of(input int n);
        return (n == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic [31:0] rdat_of(input int n);
        return (n == 1) ? m1_rdat : m0_rdat;
    endfunction

    task automatic rand_phase(input int ncyc);
        int owner, last_w;
        int beats[2], idle[2];
        bit acked[2];
        step();
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            drop(n);
            beats[n] = 0;
            idle[n]  = $urandom_range(0, 3);
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        step();
        rst_n = 1'b1;
        owner  = -1;
        last_w = 1;
        for (int t = 0; t < ncyc; t++) begin
            #2;
            if (owner < 0) begin
                check("rnd_scyc_idle", s_cyc, 0);
                check("rnd_sstb_idle", s_stb, 0);
            end else begin
                check("rnd_scyc", s_cyc, mcyc[owner]);
                check("rnd_sstb", s_stb, mstb[owner]);
                if (mcyc[owner]) begin
                    check("rnd_sadr", s_adr, madr[owner]);
                    check("rnd_swe",  s_we,  mwe[owner]);
                    check("rnd_scti", s_cti, mcti[owner]);
                    check("rnd_ssel", s_sel, msel[owner]);
                    check("rnd_sbte", s_bte, mbte[owner]);
                    if (mwe[owner]) check("rnd_swdat", s_wdat, mdat[owner]);
                end
            end
            for (int n = 0; n < 2; n++) begin
                acked[n] = (owner == n) && mcyc[n] && mstb[n];
                check(n == 0 ? "rnd_ack0" : "rnd_ack1", ack_of(n), acked[n]);
                if (acked[n] && !mwe[n]) check("rnd_rdata", rdat_of(n), ref_mem[madr[n][9:2]]);
                if (acked[n] && mwe[n]) ref_mem[madr[n][9:2]] = mdat[n];
            end
            check("rnd_no_rty_err", {28'h0, m0_rty, m1_rty, m0_err, m1_err}, 0);
            @(posedge wb_clk_i);
            // Grant held until the owner drops cyc; an idle slot always separates grants.
            if (owner >= 0) begin
                if (!mcyc[owner]) owner = -1;
            end else if (mcyc[0] && mcyc[1]) begin
                owner  = 1 - last_w;
                last_w = owner;
            end else if (mcyc[0] || mcyc[1]) begin
                owner  = mcyc[0] ? 0 : 1;
                last_w = owner;
            end
            #1;
            for (int n = 0; n < 2; n++) begin
                if (mcyc[n]) begin
                    if (acked[n]) begin
                        beats[n]--;
                        if (beats[n] == 0) begin
                            drop(n);
                            mcti[n] = CTI_CLASSIC;
                            idle[n] = $urandom_range(0, 3);
                        end else begin
                            madr[n] = madr[n] + 25'd4;
                            mdat[n] = $urandom;
                            mcti[n] = (beats[n] == 1) ? CTI_END : CTI_INCR;
                            mstb[n] = ($urandom_range(0, 3) != 0);
                        end
                    end else if (!mstb[n]) begin
                        mstb[n] = ($urandom_range(0, 3) != 0);
                    end
                end else if (idle[n] > 0) begin
                    idle[n]--;
                end else begin
                    beats[n] = $urandom_range(1, 4);
                    req(n, 1'($urandom_range(0, 1)), {15'd0, 8'($urandom_range(0, 255)), 2'b00},
                        $urandom, (beats[n] > 1) ? CTI_INCR : CTI_CLASSIC);
                    msel[n] = 4'($urandom_range(1, 15));
                    mbte[n] = 2'($urandom_range(0, 3));
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 1, 0};
        tbl[1] = '{1, 1, 1};
        tbl[2] = '{1, 0, 0};
        tbl[3] = '{1, 1, 1};
        tbl[4] = '{0, 1, 1};
        tbl[5] = '{1, 1, 0};
        tbl[6] = '{0, 0, -1};
        tbl[7] = '{0, 1, 1};
        tbl[8] = '{1, 1, 0};
        for (int n = 0; n < 2; n++) begin
            req(n, 1'b0, 25'h0, 32'h0, CTI_CLASSIC);
            drop(n);
        end

        // Reset state
        step(); step();
        #2;
        check("rst_scyc", s_cyc, 0);
        check("rst_acks", {28'h0, m0_ack, m1_ack, m0_err, m1_err}, 0);
        step();
        rst_n = 1'b1;
        #2;
        check("post_rst_scyc", s_cyc, 0);
        check("post_rst_sstb", s_stb, 0);

        // Arbitration table, each row starting from IDLE
        for (int i = 0; i < 9; i++) begin
            step();
            req(0, 1'b0, 25'h40, 32'h0, CTI_CLASSIC);
            req(1, 1'b0, 25'h80, 32'h0, CTI_CLASSIC);
            mcyc[0] = tbl[i].r0; mstb[0] = tbl[i].r0;
            mcyc[1] = tbl[i].r1; mstb[1] = tbl[i].r1;
            #2;
            check("arb_req_cycle_scyc", s_cyc, 0);
            step();
            #2;
            check("arb_scyc", s_cyc, tbl[i].exp >= 0);
            check("arb_ack0", m0_ack, tbl[i].exp == 0);
            check("arb_ack1", m1_ack, tbl[i].exp == 1);
            if (tbl[i].exp >= 0) check("arb_sadr", s_adr, (tbl[i].exp == 0) ? 32'h40 : 32'h80);
            step();
            drop(0); drop(1);
        end

        // Single master classic read
        step();
        req(1, 1'b0, 25'h20, 32'h0, CTI_CLASSIC);
        #2;
        check("rd_req_scyc", s_cyc, 0);
        check("rd_req_ack0", m0_ack, 0);
        step();
        #2;
        check("rd_scyc", s_cyc, 1);
        check("rd_ack1", m1_ack, 1);
        check("rd_dat1", m1_rdat, 32'hDEADBEEF);
        check("rd_ack0", m0_ack, 0);
        step();
        drop(1);

        // Burst integrity: m0 8-beat write, m1 requests at beat 3, then reads back
        step();
        req(0, 1'b1, 25'h100, 32'hB000_0000, CTI_INCR);
        #2;
        check("bw_req_scyc", s_cyc, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i > 0) begin
                madr[0] = 25'h100 + 25'(4 * i);
                mdat[0] = 32'hB000_0000 + 32'(i);
                mcti[0] = (i == 7) ? CTI_END : CTI_INCR;
            end
            if (i == 3) req(1, 1'b0, 25'h100, 32'h0, CTI_INCR);
            #2;
            check("bw_scyc", s_cyc, 1);
            check("bw_sadr", s_adr, 32'h100 + 32'(4 * i));
            check("bw_ack0", m0_ack, 1);
            check("bw_ack1", m1_ack, 0);
        end
        step();
        drop(0);
        #2;
        check("bw_drop_scyc", s_cyc, 0);
        step();
        #2;
        check("bw_gap_scyc", s_cyc, 0);
        check("bw_gap_ack1", m1_ack, 0);
        for (int j = 0; j < 8; j++) begin
            step();
            if (j > 0) begin
                madr[1] = 25'h100 + 25'(4 * j);
                mcti[1] = (j == 7) ? CTI_END : CTI_INCR;
            end
            #2;
            check("br_scyc", s_cyc, 1);
            check("br_ack1", m1_ack, 1);
            check("br_dat1", m1_rdat, 32'hB000_0000 + 32'(j));
        end
        step();
        drop(1);

        // Retry routed to m1 only, error routed to m0 only
        step();
        slv_mode = 1;
        req(1, 1'b0, 25'h20, 32'h0, CTI_CLASSIC);
        step();
        #2;
        check("rty_m1", m1_rty, 1);
        check("rty_m0", m0_rty, 0);
        check("rty_ack1", m1_ack, 0);
        step();
        drop(1);
        step();
        slv_mode = 2;
        req(0, 1'b0, 25'h20, 32'h0, CTI_CLASSIC);
        step();
        #2;
        check("err_m0", m0_err, 1);
        check("err_m1", m1_err, 0);
        check("err_ack0", m0_ack, 0);
        step();
        drop(0);
        slv_mode = 0;

        // Reset asserted during the third beat of an m0 burst
        step();
        req(0, 1'b1, 25'h10, 32'hC000_0000, CTI_INCR);
        step();
        #2;
        check("rb_beat0_ack", m0_ack, 1);
        step();
        madr[0] = 25'h14;
        #2;
        check("rb_beat1_ack", m0_ack, 1);
        step();
        madr[0] = 25'h18;
        #1;
        rst_n = 1'b0;
        #1;
        check("rb_scyc", s_cyc, 0);
        check("rb_sstb", s_stb, 0);
        check("rb_ack0", m0_ack, 0);
        step();
        #2;
        check("rb_held_scyc", s_cyc, 0);
        check("rb_held_ack0", m0_ack, 0);
        drop(0);
        step();
        rst_n = 1'b1;
        req(1, 1'b0, 25'h20, 32'h0, CTI_CLASSIC);
        #2;
        check("rb_idle_scyc", s_cyc, 0);
        step();
        #2;
        check("rb_regrant_scyc", s_cyc, 1);
        check("rb_regrant_ack1", m1_ack, 1);
        step();
        drop(1);

        rand_phase(2500);

        // Hung slave
        drop(0); drop(1);
        step();
        slv_mode = 3;
        req(0, 1'b0, 25'h40, 32'h0, CTI_CLASSIC);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 2) req(1, 1'b0, 25'h80, 32'h0, CTI_CLASSIC);
`ifdef WB_ARB_TIMEOUT_EN
            if (k == 9) drop(0);
            #2;
            if (k < 8) begin
                check("to_scyc_wait", s_cyc, 1);
                check("to_err_wait", m0_err, 0);
            end else if (k == 8) begin
                check("to_err_pulse", m0_err, 1);
                check("to_scyc_forced", s_cyc, 0);
                check("to_sstb_forced", s_stb, 0);
                check("to_err1", m1_err, 0);
            end else if (k == 9) begin
                check("to_idle_scyc", s_cyc, 0);
                check("to_idle_err", m0_err, 0);
            end else begin
                check("to_m1_scyc", s_cyc, 1);
                check("to_m1_sadr", s_adr, 32'h80);
            end
`else
            #2;
            check("hang_scyc", s_cyc, 1);
            check("hang_sadr", s_adr, 32'h40);
            check("hang_err", m0_err, 0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master, one-slave Wishbone arbiter in the wb_clk_i domain.
- Shares the on-chip block RAM (wb_bram4k, or another single Wishbone slave) between the PCI bridge master (wb_pci_top, master 0) and a second on-chip master (master 1, e.g. the display fetch/redraw engine).
- Grants the bus with round-robin fairness and holds each grant for a whole cycle (cyc), so bursts are never split.
- Routes all slave responses only to the granted master.

Parameters:
- ADDRESS, 25, Wishbone address width; buses are [ADDRESS-1:0].
- TIMEOUT, 64, cycles of unacknowledged stb before an error is forced. Used only with the optional feature; must be >= 2.

Ports:
- wb_clk_i  in  1  Wishbone clock; the only clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- m0_cyc_i / m1_cyc_i  in  1  master cycle request.
- m0_stb_i / m1_stb_i  in  1  master strobe.
- m0_we_i / m1_we_i  in  1  master write enable.
- m0_cti_i / m1_cti_i  in  3  master cycle-type identifier.
- m0_bte_i / m1_bte_i  in  2  master burst-type extension.
- m0_adr_i / m1_adr_i  in  ADDRESS  master address.
- m0_sel_i / m1_sel_i  in  4  master byte selects.
- m0_dat_i / m1_dat_i  in  32  master write data.
- m0_ack_o / m1_ack_o  out  1  acknowledge to master.
- m0_rty_o / m1_rty_o  out  1  retry to master.
- m0_err_o / m1_err_o  out  1  error to master.
- m0_dat_o / m1_dat_o  out  32  read data to master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
- s_cti_o  out  3  slave cycle-type identifier.
- s_bte_o  out  2  slave burst-type extension.
- s_adr_o  out  ADDRESS  slave address.
- s_sel_o  out  4  slave byte selects.
- s_dat_o  out  32  slave write data.
- s_ack_i, s_rty_i, s_err_i  in  1 each  slave responses.
- s_dat_i  in  32  slave read data.

Behaviour:
- Reset: asynchronous; wb_rst_ni low forces state IDLE, last = 1, timeout counter = 0.
  - In IDLE all s_* control outputs are 0 and every mN_ack/rty/err_o is 0.
  - Reset asserted mid-burst ends the slave cycle immediately; no response reaches either master.
- State machine: IDLE, GNT0, GNT1 (registered).
  - IDLE with only mN_cyc_i high -> GNTN.
  - IDLE with both high -> the master other than last wins (m0 wins first after reset); last is updated on grant.
  - IDLE with neither high -> stay in IDLE.
  - GNTN -> IDLE when mN_cyc_i falls. At least one IDLE cycle separates consecutive grants, giving a rearbitration point.
- Latency: grant is visible on the cycle after the cyc request. Requesting masters must already hold cyc/stb until ack under Wishbone rules.
- Datapath in GNTN (combinational mux):
  - s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i.
  - s_we/cti/bte/adr/sel/dat_o come from master N.
  - mN_ack/rty/err_o = s_*_i gated by mN_cyc_i.
  - The non-granted master's ack/rty/err are forced to 0.
  - mN_dat_o = s_dat_i for both masters; data is qualified by ack.
- Bursts: cti 3'b010 incrementing bursts pass through unchanged. Grant is released only on cyc drop, never on cti 3'b111.
- Simultaneous events: a cyc drop by the granted master while the other master requests -> IDLE for one cycle, then grant to the waiting master. Only one slave access is ever active.
- A slave response arriving in IDLE is ignored.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - A counter clears on any s_ack/rty/err_i or on stb low, and increments while the granted stb is high.
  - At count == TIMEOUT-1: mN_err_o pulses high for 1 cycle, s_cyc_o/s_stb_o are forced low that cycle, and the state goes to IDLE.
  - The master must then drop cyc; re-requesting with cyc still high is treated as a new request after the IDLE cycle.
- Undefined: no counter, no forced error; a hung slave holds the grant forever.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encodings ST_IDLE = 2'd0, ST_GNT0 = 2'd1, ST_GNT1 = 2'd2;
  - CTI constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_END = 3'b111;
  - timeout counter width = clog2(TIMEOUT).
- One sub-module, wb_arb_mux: a purely combinational grant-indexed mux for master->slave signals and response gating. The FSM, last-served register and timeout counter stay in wb_arb2.

Test Plan:
- Reset mid-burst: m0 granted, 4-beat cti=010 write to 0x000010, wb_rst_ni low after beat 2 -> s_cyc_o = 0 within the same cycle; no ack to m0; after release the state is IDLE.
- Single master: m1 classic read of 0x000020 (BRAM holds 0xDEADBEEF) -> s_cyc_o high on the cycle after m1_cyc_i; m1_ack_o = 1 with m1_dat_o = 0xDEADBEEF; m0_ack_o stays 0 throughout.
- Contention: both raise cyc in the same cycle -> m0 granted first. After m0 drops cyc, 1 IDLE cycle, then m1 granted. Repeat both requesting -> m1 first time, m0 next (alternation).
- Burst integrity: m0 8-beat incrementing write 0x100..0x11C while m1 requests at beat 3 -> all 8 beats reach the slave uninterrupted; m1 granted only after m0_cyc_i falls; readback matches.
- Slave retry/err: slave asserts s_rty_i on an m1 access -> m1_rty_o = 1 for that cycle and m0_rty_o = 0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT = 8): slave never acks an m0 read -> m0_err_o pulses exactly 8 cycles after stb rose, s_cyc_o low that cycle, then m1 can be granted. Without the macro -> no err and the grant is held.
